// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  idex_mem_read_i;
  logic [REG_ADDR_W-1:0] idex_rt_i;
  logic [REG_ADDR_W-1:0] ifid_rs_i;
  logic [REG_ADDR_W-1:0] ifid_rt_i;
  logic                  branch_taken_i;
  logic                  md_start_i;
  logic                  pc_en_o;
  logic                  ifid_en_o;
  logic                  idex_en_o;
  logic                  ifid_flush_o;
  logic                  idex_flush_o;
  logic [1:0]            state_o;

  modport master (
    output idex_mem_read_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i, md_start_i,
    input  pc_en_o, ifid_en_o, idex_en_o, ifid_flush_o, idex_flush_o, state_o
  );

  modport slave (
    input  idex_mem_read_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i, md_start_i,
    output pc_en_o, ifid_en_o, idex_en_o, ifid_flush_o, idex_flush_o, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end stall/flush controller: load-use bubble, taken-branch flush and
// multi-cycle mul/div stall. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES  = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cycles_o
`endif
);
  localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1
  } state_e;

  state_e                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [REG_ADDR_W-1:0] ld_rt;
  logic                  load_use;
  logic                  pc_en, ifid_en, idex_en, ifid_flush, idex_flush;

  assign ld_rt    = hz.idex_rt_i;
  assign load_use = hz.idex_mem_read_i && (ld_rt != '0) &&
                    ((ld_rt == hz.ifid_rs_i) || (ld_rt == hz.ifid_rt_i));

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Reset is folded in here so the enables read as "run" while reset is held.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    if (!reset) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        MD_BUSY: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: begin
          state_nxt = RUN;
          if (hz.md_start_i) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            state_nxt = MD_BUSY;
            cnt_nxt   = CNT_W'(MD_CYCLES - 1);
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (hz.branch_taken_i) begin
            ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign hz.pc_en_o      = pc_en;
  assign hz.ifid_en_o    = ifid_en;
  assign hz.idex_en_o    = idex_en;
  assign hz.ifid_flush_o = ifid_flush;
  assign hz.idex_flush_o = idex_flush;
  assign hz.state_o      = reset ? state : RUN;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_o <= '0;
      flush_cycles_o <= '0;
    end else begin
      if (!pc_en && (stall_cycles_o != 32'hFFFF_FFFF))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if ((ifid_flush || idex_flush) && (flush_cycles_o != 32'hFFFF_FFFF))
        flush_cycles_o <= flush_cycles_o + 32'd1;
    end
  end
`endif
endmodule
